hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Generalises to N source operands and configurable register-address width.
- Adds three behaviours:
  - load-use and branch-operand interlocks;
  - multi-cycle data-memory wait stalls driven by a req/ready handshake, with a timeout FSM that freezes the pipeline on fault;
  - a saturating stall-cycle performance counter.

Parameters:
- REG_W, 4, register address width (2**REG_W architectural registers).
- NUM_SRC, 2, source operands per instruction in D and E.
- ZERO_REG, 1, when 1 register 0 is hardwired zero: it never matches and is never forwarded.
- MEM_TIMEOUT, 64, max consecutive memory-wait cycles before FAULT; 0 disables the timeout.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- srcD  in  NUM_SRC*REG_W  D-stage source registers; operand i is at [i*REG_W +: REG_W].
- src_validD  in  NUM_SRC  D-stage operand i is actually read.
- srcE  in  NUM_SRC*REG_W  E-stage source registers.
- src_validE  in  NUM_SRC  E-stage operand valid.
- branchD  in  1  D holds a branch; its operands are compared in D.
- branch_takenD  in  1  branch resolved taken in D.
- reg_wrenE, mem_to_regE  in  1 each  E writes a register / E is a load.
- dst_regE  in  REG_W  E destination.
- reg_wrenM, mem_to_regM  in  1 each  M writes a register / M is a load.
- dst_regM  in  REG_W  M destination.
- reg_wrenW  in  1  W writes a register.
- dst_regW  in  REG_W  W destination.
- mem_req_M  in  1  M is accessing data memory.
- mem_ready_M  in  1  data memory completes this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- stallF, stallD, stallE, stallM  out  1 each  hold the stage register.
- flushD, flushE, flushW  out  1 each  insert a bubble into the stage register.
- forwardD  out  NUM_SRC*2  per-operand D forwarding select.
- forwardE  out  NUM_SRC*2  per-operand E forwarding select.
- mem_fault  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  count of cycles with stallF=1.

Behaviour:
- Match rule:
  - match(src, dst, wren) = wren & valid & (src==dst) & !(ZERO_REG & src==0).
  - All matches are evaluated per operand, independently.
- forwardE per operand (youngest producer wins, oldest source has the highest code):
  - 2'b01 if match with M and !mem_to_regM;
  - else 2'b10 if match with W;
  - else 2'b00.
- forwardD per operand, applied only when branchD:
  - 2'b01 if match E;
  - else 2'b10 if match M;
  - else 2'b11 if match W;
  - else 2'b00.
  - When branchD=0, forwardD=0.
- Interlock, lu (combinational):
  - any D operand matches E with mem_to_regE (load-use); OR
  - branchD & match E (ALU result not ready in D); OR
  - branchD & match M with mem_to_regM.
- Memory wait: mw = mem_req_M & !mem_ready_M.
- FSM states:
  - RUN: reset state. mw -> MEM_WAIT, wait_cnt <= 1.
  - MEM_WAIT:
    - mem_ready_M or !mem_req_M -> RUN, wait_cnt <= 0.
    - else if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT -> FAULT.
    - else wait_cnt++.
  - FAULT: terminal until rst_n. mem_fault=1.
- Output priority, highest first:
  - FAULT: all stalls=1, all flushes=0.
  - mw (RUN or MEM_WAIT): stallF/D/E/M=1, flushW=1, flushD=flushE=0.
  - lu: stallF=stallD=1, flushE=1, flushD=0. A branch is not resolved while interlocked.
  - else: flushD = branchD & branch_takenD; all other stall/flush outputs are 0.
- Stall counter:
  - stall_cycles increments each cycle stallF=1 and saturates at all-ones.
  - perf_clr has priority over increment.
- Reset:
  - Asynchronous.
  - state=RUN, wait_cnt=0, stall_cycles=0, mem_fault=0.
  - With idle inputs, every other output is 0.
  - Reset during MEM_WAIT or FAULT returns to RUN immediately.
- All stall/flush/forward outputs are combinational, with zero-cycle latency from inputs and state.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t encodings: FWD_NONE, FWD_E, FWD_M, FWD_W;
  - hz_state_t: RUN, MEM_WAIT, FAULT.
- One sub-module, hazard_fwd_sel, instantiated per operand via generate. It takes one src/valid plus E/M/W destination info and produces forwardD/forwardE codes and the lu contribution.
- FSM and counter live in the top level.

Test Plan:
- ALU forward:
  - Stimulus: srcE[0]=3, reg_wrenM=1, dst_regM=3, reg_wrenW=1, dst_regW=3.
  - Required: forwardE[1:0]=01 (M wins over W); stall/flush outputs 0.
- Load-use:
  - Stimulus: mem_to_regE=1, reg_wrenE=1, dst_regE=5, srcD[1]=5, valid.
  - Required: stallF=stallD=flushE=1 for exactly that cycle; stall_cycles increments by 1.
- Branch with taken resolution:
  - Stimulus: branchD=1, srcD[0]=2, reg_wrenM=1, dst_regM=2, branch_takenD=1.
  - Required: forwardD[1:0]=10, flushD=1, no stall.
  - Same stimulus with dst_regE=2 and reg_wrenE=1: stall, flushE=1, flushD=0.
- Memory wait:
  - Stimulus: mem_req_M=1, mem_ready_M=0 for 3 cycles, then 1.
  - Required: stallF..M=1 and flushW=1 for 3 cycles; return to RUN; stall_cycles=3.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, ready held 0.
  - Required: FAULT after the 5th wait cycle; mem_fault=1 and all stalls stay 1 after the request drops; rst_n low clears to RUN.
- Zero register and saturation:
  - Stimulus: dst_regM=0 with srcE=0 and ZERO_REG=1; separately CNT_W=2 with 5 stalls.
  - Required: forwardE=00; stall_cycles=3, then 0 after perf_clr.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forwarding
// select encodings and the memory-wait FSM state.
package hazard_pkg;

   // D-stage select codes; the older the producer, the higher the code.
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_E    = 2'b01,
      FWD_M    = 2'b10,
      FWD_W    = 2'b11
   } fwd_sel_t;

   // E has no E-stage producer, so its M/W codes sit one step lower.
   localparam logic [1:0] FWDE_NONE = 2'b00;
   localparam logic [1:0] FWDE_M    = 2'b01;
   localparam logic [1:0] FWDE_W    = 2'b10;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FAULT    = 2'b10
   } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand hazard slice: producer matching, D/E forwarding selects and
// this operand's contribution to the load-use / branch interlock.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_W    = 4,
   parameter int ZERO_REG = 1
) (
   input  logic [REG_W-1:0] src_d,
   input  logic             valid_d,
   input  logic [REG_W-1:0] src_e,
   input  logic             valid_e,
   input  logic             branch_d,
   input  logic             reg_wren_e,
   input  logic             mem_to_reg_e,
   input  logic [REG_W-1:0] dst_reg_e,
   input  logic             reg_wren_m,
   input  logic             mem_to_reg_m,
   input  logic [REG_W-1:0] dst_reg_m,
   input  logic             reg_wren_w,
   input  logic [REG_W-1:0] dst_reg_w,
   output logic [1:0]       fwd_d,
   output logic [1:0]       fwd_e,
   output logic             lu
);

   // Register 0 is never a real dependency when it is hardwired to zero.
   function automatic logic hit(input logic [REG_W-1:0] src,
                                input logic             vld,
                                input logic [REG_W-1:0] dst,
                                input logic             wren);
      hit = wren && vld && (src == dst) && !((ZERO_REG != 0) && (src == '0));
   endfunction

   logic d_hit_e;
   logic d_hit_m;
   logic d_hit_w;
   logic e_hit_m;
   logic e_hit_w;

   always_comb begin
      d_hit_e = hit(src_d, valid_d, dst_reg_e, reg_wren_e);
      d_hit_m = hit(src_d, valid_d, dst_reg_m, reg_wren_m);
      d_hit_w = hit(src_d, valid_d, dst_reg_w, reg_wren_w);
      e_hit_m = hit(src_e, valid_e, dst_reg_m, reg_wren_m);
      e_hit_w = hit(src_e, valid_e, dst_reg_w, reg_wren_w);
   end

   // A load in M has no data yet, so E falls back to an older W copy if any.
   always_comb begin
      fwd_e = FWDE_NONE;
      if (e_hit_m && !mem_to_reg_m) begin
         fwd_e = FWDE_M;
      end else if (e_hit_w) begin
         fwd_e = FWDE_W;
      end
   end

   always_comb begin
      fwd_d = FWD_NONE;
      if (branch_d) begin
         if (d_hit_e) begin
            fwd_d = FWD_E;
         end else if (d_hit_m) begin
            fwd_d = FWD_M;
         end else if (d_hit_w) begin
            fwd_d = FWD_W;
         end
      end
   end

   // Branches compare in D, so an E producer or an M load is still too late.
   always_comb begin
      lu = (d_hit_e && mem_to_reg_e)
         || (branch_d && d_hit_e)
         || (branch_d && d_hit_m && mem_to_reg_m);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline, with memory
// wait stalls, a timeout fault FSM and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W       = 4,
   parameter int NUM_SRC     = 2,
   parameter int ZERO_REG    = 1,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SRC*REG_W-1:0] srcD,
   input  logic [NUM_SRC-1:0]       src_validD,
   input  logic [NUM_SRC*REG_W-1:0] srcE,
   input  logic [NUM_SRC-1:0]       src_validE,
   input  logic                     branchD,
   input  logic                     branch_takenD,
   input  logic                     reg_wrenE,
   input  logic                     mem_to_regE,
   input  logic [REG_W-1:0]         dst_regE,
   input  logic                     reg_wrenM,
   input  logic                     mem_to_regM,
   input  logic [REG_W-1:0]         dst_regM,
   input  logic                     reg_wrenW,
   input  logic [REG_W-1:0]         dst_regW,
   input  logic                     mem_req_M,
   input  logic                     mem_ready_M,
   input  logic                     perf_clr,
   output logic                     stallF,
   output logic                     stallD,
   output logic                     stallE,
   output logic                     stallM,
   output logic                     flushD,
   output logic                     flushE,
   output logic                     flushW,
   output logic [NUM_SRC*2-1:0]     forwardD,
   output logic [NUM_SRC*2-1:0]     forwardE,
   output logic                     mem_fault,
   output logic [CNT_W-1:0]         stall_cycles,
   output hz_state_t                dbg_state
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

   logic [NUM_SRC-1:0] lu_vec;
   logic               lu;
   logic               mw;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         hazard_fwd_sel #(
            .REG_W    (REG_W),
            .ZERO_REG (ZERO_REG)
         ) u_fwd_sel (
            .src_d        (srcD[gi*REG_W +: REG_W]),
            .valid_d      (src_validD[gi]),
            .src_e        (srcE[gi*REG_W +: REG_W]),
            .valid_e      (src_validE[gi]),
            .branch_d     (branchD),
            .reg_wren_e   (reg_wrenE),
            .mem_to_reg_e (mem_to_regE),
            .dst_reg_e    (dst_regE),
            .reg_wren_m   (reg_wrenM),
            .mem_to_reg_m (mem_to_regM),
            .dst_reg_m    (dst_regM),
            .reg_wren_w   (reg_wrenW),
            .dst_reg_w    (dst_regW),
            .fwd_d        (forwardD[gi*2 +: 2]),
            .fwd_e        (forwardE[gi*2 +: 2]),
            .lu           (lu_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      lu = |lu_vec;
      mw = mem_req_M && !mem_ready_M;
   end

   hz_state_t         state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              fault_q, fault_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   // wait_cnt counts consecutive wait cycles already spent in MEM_WAIT.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (mw) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready_M || !mem_req_M) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_CNT)) begin
               state_d = FAULT;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      fault_d = (state_d == FAULT);
   end

   // Fault freezes everything; a pending memory wait beats any interlock.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushW = 1'b0;
      if (state_q == FAULT) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else if (mw) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (lu) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end else begin
         flushD = branchD && branch_takenD;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (perf_clr) begin
         stall_cnt_d = '0;
      end else if (stallF && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         fault_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         fault_q     <= fault_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_fault    = fault_q;
   assign stall_cycles = stall_cnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a wide-counter and a 2-bit-counter instance
// share stimulus; a negedge monitor checks against a queue of expectations.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int REG_W = 4;
   localparam int NS    = 2;
   localparam int OBS_W = 54;

   localparam logic [6:0] SF_NONE = 7'b0000000;
   localparam logic [6:0] SF_LU   = 7'b1100010;
   localparam logic [6:0] SF_MW   = 7'b1111001;
   localparam logic [6:0] SF_FLT  = 7'b1111000;
   localparam logic [6:0] SF_BRT  = 7'b0000100;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NS*REG_W-1:0] srcD, srcE;
   logic [NS-1:0]       src_validD, src_validE;
   logic                branchD, branch_takenD;
   logic                reg_wrenE, mem_to_regE, reg_wrenM, mem_to_regM, reg_wrenW;
   logic [REG_W-1:0]    dst_regE, dst_regM, dst_regW;
   logic                mem_req_M, mem_ready_M, perf_clr;

   logic                stallF, stallD, stallE, stallM, flushD, flushE, flushW;
   logic [NS*2-1:0]     forwardD, forwardE;
   logic                mem_fault;
   logic [15:0]         stall_cycles;
   hz_state_t           dbg_state;

   logic                s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW;
   logic [NS*2-1:0]     s_forwardD, s_forwardE;
   logic                s_mem_fault;
   logic [1:0]          s_stall_cycles;
   hz_state_t           s_dbg_state;

   hazard_ctrl #(.REG_W(REG_W), .NUM_SRC(NS), .ZERO_REG(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .srcD(srcD), .src_validD(src_validD), .srcE(srcE),
      .src_validE(src_validE), .branchD(branchD), .branch_takenD(branch_takenD),
      .reg_wrenE(reg_wrenE), .mem_to_regE(mem_to_regE), .dst_regE(dst_regE),
      .reg_wrenM(reg_wrenM), .mem_to_regM(mem_to_regM), .dst_regM(dst_regM),
      .reg_wrenW(reg_wrenW), .dst_regW(dst_regW), .mem_req_M(mem_req_M),
      .mem_ready_M(mem_ready_M), .perf_clr(perf_clr), .stallF(stallF), .stallD(stallD),
      .stallE(stallE), .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .forwardD(forwardD), .forwardE(forwardE), .mem_fault(mem_fault),
      .stall_cycles(stall_cycles), .dbg_state(dbg_state)
   );

   hazard_ctrl #(.REG_W(REG_W), .NUM_SRC(NS), .ZERO_REG(1), .MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .srcD(srcD), .src_validD(src_validD), .srcE(srcE),
      .src_validE(src_validE), .branchD(branchD), .branch_takenD(branch_takenD),
      .reg_wrenE(reg_wrenE), .mem_to_regE(mem_to_regE), .dst_regE(dst_regE),
      .reg_wrenM(reg_wrenM), .mem_to_regM(mem_to_regM), .dst_regM(dst_regM),
      .reg_wrenW(reg_wrenW), .dst_regW(dst_regW), .mem_req_M(mem_req_M),
      .mem_ready_M(mem_ready_M), .perf_clr(perf_clr), .stallF(s_stallF), .stallD(s_stallD),
      .stallE(s_stallE), .stallM(s_stallM), .flushD(s_flushD), .flushE(s_flushE),
      .flushW(s_flushW), .forwardD(s_forwardD), .forwardE(s_forwardE),
      .mem_fault(s_mem_fault), .stall_cycles(s_stall_cycles), .dbg_state(s_dbg_state)
   );

   logic [OBS_W-1:0] obs;
   assign obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardD, forwardE,
                 mem_fault, dbg_state, stall_cycles,
                 s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW,
                 s_forwardD, s_forwardE, s_mem_fault, s_dbg_state, s_stall_cycles};

   // scoreboard
   logic [OBS_W-1:0] exp_q[$];
   string            name_q[$];
   logic             obs_valid = 1'b0;
   int               checks = 0;
   int               errors = 0;
   logic [15:0]      m_cnt = '0;
   logic [1:0]       m_sat = '0;

   always @(negedge clk) begin
      if (obs_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation: got %h required none", obs);
         end else begin
            logic [OBS_W-1:0] e;
            string            n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (obs !== e) begin
               errors++;
               $display("FAIL %s: got %h required %h", n, obs, e);
            end
         end
      end
   end

   // driver tasks
   task automatic idle();
      srcD = '0; src_validD = '0; srcE = '0; src_validE = '0;
      branchD = 1'b0; branch_takenD = 1'b0;
      reg_wrenE = 1'b0; mem_to_regE = 1'b0; dst_regE = '0;
      reg_wrenM = 1'b0; mem_to_regM = 1'b0; dst_regM = '0;
      reg_wrenW = 1'b0; dst_regW = '0;
      mem_req_M = 1'b0; mem_ready_M = 1'b0; perf_clr = 1'b0;
   endtask

   // Called #1 after a posedge with inputs already driven; returns likewise.
   task automatic step(input string name, input logic [6:0] sf, input logic [3:0] fd,
                       input logic [3:0] fe, input hz_state_t st);
      logic [17:0] core;
      if (!rst_n) begin
         m_cnt = '0;
         m_sat = '0;
      end
      core = {sf, fd, fe, (st == FAULT), st};
      exp_q.push_back({core, m_cnt, core, m_sat});
      name_q.push_back(name);
      obs_valid = 1'b1;
      @(posedge clk);
      if (!rst_n || perf_clr) begin
         m_cnt = '0;
         m_sat = '0;
      end else if (sf[6]) begin
         if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
         if (m_sat != 2'b11) m_sat = m_sat + 2'd1;
      end
      #1;
      obs_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      @(posedge clk);
      #1;
      step("reset", SF_NONE, 4'b0000, 4'b0000, RUN);
      rst_n = 1'b1;
      step("idle", SF_NONE, 4'b0000, 4'b0000, RUN);

      srcE = {4'd0, 4'd3}; src_validE = 2'b01;
      reg_wrenM = 1'b1; dst_regM = 4'd3; reg_wrenW = 1'b1; dst_regW = 4'd3;
      step("alu_fwd_m", SF_NONE, 4'b0000, 4'b0001, RUN);

      srcE = {4'd3, 4'd7}; src_validE = 2'b11; mem_to_regM = 1'b1;
      step("load_m_fwd_w", SF_NONE, 4'b0000, 4'b1000, RUN);

      idle();
      mem_to_regE = 1'b1; reg_wrenE = 1'b1; dst_regE = 4'd5;
      srcD = {4'd5, 4'd0}; src_validD = 2'b10;
      step("load_use", SF_LU, 4'b0000, 4'b0000, RUN);
      idle();
      step("after_load_use", SF_NONE, 4'b0000, 4'b0000, RUN);

      branchD = 1'b1; branch_takenD = 1'b1; srcD = {4'd0, 4'd2}; src_validD = 2'b01;
      reg_wrenM = 1'b1; dst_regM = 4'd2;
      step("branch_taken", SF_BRT, 4'b0010, 4'b0000, RUN);
      reg_wrenE = 1'b1; dst_regE = 4'd2;
      step("branch_interlock", SF_LU, 4'b0001, 4'b0000, RUN);

      idle();
      branchD = 1'b1; srcD = {4'd9, 4'd0}; src_validD = 2'b10;
      reg_wrenW = 1'b1; dst_regW = 4'd9;
      step("branch_fwd_w", SF_NONE, 4'b1100, 4'b0000, RUN);

      idle();
      branchD = 1'b1; srcD = {4'd0, 4'd4}; src_validD = 2'b01;
      reg_wrenM = 1'b1; mem_to_regM = 1'b1; dst_regM = 4'd4;
      step("branch_load_m", SF_LU, 4'b0010, 4'b0000, RUN);

      idle();
      srcE = '0; src_validE = 2'b11; srcD = '0; src_validD = 2'b11;
      reg_wrenM = 1'b1; dst_regM = '0; reg_wrenW = 1'b1; dst_regW = '0;
      reg_wrenE = 1'b1; mem_to_regE = 1'b1; dst_regE = '0;
      step("zero_reg", SF_NONE, 4'b0000, 4'b0000, RUN);

      idle();
      perf_clr = 1'b1;
      step("perf_clr_a", SF_NONE, 4'b0000, 4'b0000, RUN);

      idle();
      mem_req_M = 1'b1;
      step("mem_wait_1", SF_MW, 4'b0000, 4'b0000, RUN);
      step("mem_wait_2", SF_MW, 4'b0000, 4'b0000, MEM_WAIT);
      step("mem_wait_3", SF_MW, 4'b0000, 4'b0000, MEM_WAIT);
      mem_ready_M = 1'b1;
      step("mem_ready", SF_NONE, 4'b0000, 4'b0000, MEM_WAIT);
      idle();
      step("mem_back_run", SF_NONE, 4'b0000, 4'b0000, RUN);

      mem_to_regE = 1'b1; reg_wrenE = 1'b1; dst_regE = 4'd6;
      srcD = {4'd0, 4'd6}; src_validD = 2'b01;
      step("sat_stall_4", SF_LU, 4'b0000, 4'b0000, RUN);
      step("sat_stall_5", SF_LU, 4'b0000, 4'b0000, RUN);
      idle();
      step("sat_hold", SF_NONE, 4'b0000, 4'b0000, RUN);
      perf_clr = 1'b1;
      step("perf_clr_b", SF_NONE, 4'b0000, 4'b0000, RUN);
      idle();
      step("cleared", SF_NONE, 4'b0000, 4'b0000, RUN);

      mem_req_M = 1'b1;
      step("timeout_1", SF_MW, 4'b0000, 4'b0000, RUN);
      for (int i = 2; i <= 5; i++) begin
         step($sformatf("timeout_%0d", i), SF_MW, 4'b0000, 4'b0000, MEM_WAIT);
      end
      step("fault_req", SF_FLT, 4'b0000, 4'b0000, FAULT);
      idle();
      branchD = 1'b1; branch_takenD = 1'b1;
      step("fault_idle", SF_FLT, 4'b0000, 4'b0000, FAULT);

      idle();
      rst_n = 1'b0;
      step("fault_reset", SF_NONE, 4'b0000, 4'b0000, RUN);
      rst_n = 1'b1;
      step("post_reset", SF_NONE, 4'b0000, 4'b0000, RUN);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
